// File: rtl/sample_result_narrower_if.sv
// rtl/sample_result_narrower_if.sv - input/output valid/ready handshake bundle for sample_result_narrower
//
// Purpose: groups the upstream sample stream (in_*) and downstream narrowed stream (out_*)
// of the narrower into a single interface.
// Modports:
//   master - upstream producer / downstream consumer side (drives in_*, out_ready)
//   slave  - the narrower itself (drives in_ready, out_*)
// Signals:
//   in_valid   in_data/shift valid
//   in_ready   narrower can accept a sample this cycle
//   in_data    signed wide result, BITSIN bits
//   shift      right-shift amount sampled with in_data
//   out_valid  out_data valid
//   out_ready  consumer accepts out_data this cycle
//   out_data   signed narrowed sample, BITSOUT bits
//   out_sat    out_data was clipped; travels with the sample

interface sample_result_narrower_if #(
    parameter int BITSIN     = 32,
    parameter int BITSOUT    = 16,
    parameter int SHIFT_BITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BITSIN-1:0]     in_data;
    logic [SHIFT_BITS-1:0] shift;
    logic                  out_valid;
    logic                  out_ready;
    logic [BITSOUT-1:0]    out_data;
    logic                  out_sat;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output shift,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sat
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  shift,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sat
    );
endinterface

// File: rtl/sample_result_narrower.sv
// rtl/sample_result_narrower.sv - round/shift/saturate narrowing stage with 2-entry skid buffer
//
// Purpose: takes the wide signed result of the sample arithmetic unit, applies a per-sample
// arithmetic right shift with round-half-up, saturates to BITSOUT bits and hands the
// result downstream through a 2-entry valid/ready skid buffer. Saturation events are
// counted for debug readout.
// Ports:
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   bus          sample_result_narrower_if.slave (in_* accept side, out_* deliver side)
//   clear_count  synchronous clear of sat_count (wins over an increment)
//   sat_count    saturating count of clipped samples accepted into the buffer
// BITSOUT must be smaller than BITSIN.

module sample_result_narrower #(
    parameter int BITSIN     = 32,
    parameter int BITSOUT    = 16,
    parameter int SHIFT_BITS = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    sample_result_narrower_if.slave       bus,
    input  logic                          clear_count,
    output logic [15:0]                   sat_count
);

    // One guard bit above the input so the rounding add cannot overflow.
    localparam int W = BITSIN + 1;
    localparam logic signed [W-1:0] SAT_MAX = W'((64'sd1 <<< (BITSOUT - 1)) - 64'sd1);
    localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [BITSOUT-1:0]  OUT_MAX = {1'b0, {(BITSOUT-1){1'b1}}};
    localparam logic [BITSOUT-1:0]  OUT_MIN = {1'b1, {(BITSOUT-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    buf_state_t         state;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [BITSOUT-1:0] head_data;
    logic               head_sat;
    logic [BITSOUT-1:0] tail_data;
    logic               tail_sat;

    // ------------------------------------------------------------------
    // Combinational narrowing of the sample presented on the input side
    // ------------------------------------------------------------------
    logic [31:0]        shift_amt;
    logic signed [W-1:0] ext;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] shifted;
    logic [BITSOUT-1:0] new_data;
    logic               new_sat;

    always_comb begin
        shift_amt = 32'(bus.shift);
        if (shift_amt > 32'(BITSIN - 1)) begin
            shift_amt = 32'(BITSIN - 1);
        end
        ext = {bus.in_data[BITSIN-1], bus.in_data};
        // Adding half an LSB of the result before the floor shift rounds halves toward +inf.
        rnd = (shift_amt == 32'd0) ? '0 : (W'(1) << (shift_amt - 32'd1));
        sum = ext + rnd;
        shifted = sum >>> shift_amt;
        new_sat = 1'b0;
        new_data = shifted[BITSOUT-1:0];
        if (shifted > SAT_MAX) begin
            new_data = OUT_MAX;
            new_sat  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            new_data = OUT_MIN;
            new_sat  = 1'b1;
        end
    end

    logic accept;
    logic take;

    assign accept = bus.in_valid && in_ready_r;
    assign take   = out_valid_r && bus.out_ready;

    // ------------------------------------------------------------------
    // Skid buffer: head feeds the output directly, tail only fills in TWO.
    // in_ready/out_valid are state-registered so out_ready never reaches in_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_data   <= '0;
            head_sat    <= 1'b0;
            tail_data   <= '0;
            tail_sat    <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head_data   <= new_data;
                        head_sat    <= new_sat;
                        out_valid_r <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && take) begin
                        head_data <= new_data;
                        head_sat  <= new_sat;
                    end else if (accept) begin
                        tail_data  <= new_data;
                        tail_sat   <= new_sat;
                        in_ready_r <= 1'b0;
                        state      <= ST_TWO;
                    end else if (take) begin
                        out_valid_r <= 1'b0;
                        state       <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (take) begin
                        head_data  <= tail_data;
                        head_sat   <= tail_sat;
                        in_ready_r <= 1'b1;
                        state      <= ST_ONE;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Counted at accept time so a stalled consumer does not delay the debug count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_count <= '0;
        end else if (clear_count) begin
            sat_count <= '0;
        end else if (accept && new_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = head_data;
    assign bus.out_sat   = head_sat;

endmodule
